// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU control path: opcodes, ALU operation
// encodings and the sequencer state encoding.
package cpu_pkg;

    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_RSH  = 8'h08;
    localparam logic [7:0] OP_ALSH = 8'h0C;
    localparam logic [7:0] OP_ARSH = 8'h0F;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_ADDC = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_CMP  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_NOT  = 4'd8;
    localparam logic [3:0] ALU_LSH  = 4'd9;
    localparam logic [3:0] ALU_RSH  = 4'd10;
    localparam logic [3:0] ALU_ALSH = 4'd11;
    localparam logic [3:0] ALU_ARSH = 4'd12;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle of instruction-memory, register-file, ALU and flags control signals
// between the sequencer (master) and the rest of the CPU (slave).
interface cpu_sequencer_if;
    import cpu_pkg::*;

    logic                run;
    logic                mem_ack;
    logic [15:0]         mem_rdata;
    logic                mem_req;
    logic [15:0]         pc;
    logic [15:0]         ir;
    logic [3:0]          alu_op;
    logic                alu_en;
    logic [3:0]          rf_raddr_a;
    logic [3:0]          rf_raddr_b;
    logic [3:0]          rf_waddr;
    logic                rf_we;
    logic                flags_we;
    logic                illegal;
    logic [STATE_W-1:0]  state;
    logic [15:0]         instr_count;

    modport master (
        input  run, mem_ack, mem_rdata,
        output mem_req, pc, ir, alu_op, alu_en, rf_raddr_a, rf_raddr_b,
               rf_waddr, rf_we, flags_we, illegal, state, instr_count
    );

    modport slave (
        output run, mem_ack, mem_rdata,
        input  mem_req, pc, ir, alu_op, alu_en, rf_raddr_a, rf_raddr_b,
               rf_waddr, rf_we, flags_we, illegal, state, instr_count
    );

endinterface

// File: rtl/cpu_sequencer_decoder.sv
// Instruction field splitter: opcode in the high byte, rdst/rsrc nibbles
// (or an 8-bit immediate) in the low byte.
module decoder (
    input  logic [15:0] instr,
    output logic [7:0]  opcode,
    output logic [3:0]  rdst,
    output logic [3:0]  rsrc,
    output logic [7:0]  imm
);

    assign opcode = instr[15:8];
    assign rdst   = instr[7:4];
    assign rsrc   = instr[3:0];
    assign imm    = instr[7:0];

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit CPU.
// One instruction in flight; an unknown opcode parks the machine in HALT.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus
);

    state_e      state_r;
    state_e      next_state_s;
    logic [15:0] pc_r;
    logic [15:0] ir_r;
    logic [3:0]  alu_op_r;
    logic        illegal_r;
    logic [15:0] instr_count_r;
    logic        mem_req_r;
    logic        alu_en_r;
    logic        rf_we_r;
    logic        flags_we_r;

    logic [7:0]  opcode_s;
    logic [3:0]  rdst_s;
    logic [3:0]  rsrc_s;
    logic [7:0]  imm_unused_s;
    logic        legal_s;
    logic [3:0]  dec_alu_op_s;
    logic        sets_flags_s;

    decoder u_decoder (
        .instr  (ir_r),
        .opcode (opcode_s),
        .rdst   (rdst_s),
        .rsrc   (rsrc_s),
        .imm    (imm_unused_s)
    );

    // Opcode legality check and ALU operation mapping
    always_comb begin
        legal_s      = 1'b1;
        dec_alu_op_s = ALU_ADD;
        case (opcode_s)
            OP_ADD:  dec_alu_op_s = ALU_ADD;
            OP_ADDU: dec_alu_op_s = ALU_ADDU;
            OP_ADDC: dec_alu_op_s = ALU_ADDC;
            OP_SUB:  dec_alu_op_s = ALU_SUB;
            OP_CMP:  dec_alu_op_s = ALU_CMP;
            OP_AND:  dec_alu_op_s = ALU_AND;
            OP_OR:   dec_alu_op_s = ALU_OR;
            OP_XOR:  dec_alu_op_s = ALU_XOR;
            OP_NOT:  dec_alu_op_s = ALU_NOT;
            OP_LSH:  dec_alu_op_s = ALU_LSH;
            OP_RSH:  dec_alu_op_s = ALU_RSH;
            OP_ALSH: dec_alu_op_s = ALU_ALSH;
            OP_ARSH: dec_alu_op_s = ALU_ARSH;
            default: legal_s      = 1'b0;
        endcase
    end

    // Flag-producing operations among the decoded ALU ops
    always_comb begin
        sets_flags_s = 1'b0;
        case (dec_alu_op_s)
            ALU_ADD, ALU_ADDC, ALU_SUB, ALU_CMP: sets_flags_s = 1'b1;
            default:                            sets_flags_s = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = bus.run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  next_state_s = bus.mem_ack ? ST_DECODE : ST_FETCH;
            ST_DECODE: next_state_s = legal_s ? ST_EXEC : ST_HALT;
            ST_EXEC:   next_state_s = ST_WB;
            ST_WB:     next_state_s = bus.run ? ST_FETCH : ST_IDLE;
            ST_HALT:   next_state_s = ST_HALT;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register plus strobes registered from the upcoming state, so each
    // strobe is high for exactly the cycles spent in its state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            alu_en_r   <= 1'b0;
            flags_we_r <= 1'b0;
            rf_we_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            mem_req_r  <= (next_state_s == ST_FETCH);
            alu_en_r   <= (next_state_s == ST_EXEC);
            flags_we_r <= (next_state_s == ST_EXEC) && sets_flags_s;
            rf_we_r    <= (next_state_s == ST_WB) && (alu_op_r != ALU_CMP);
        end
    end

    // Fetch address, instruction register, ALU op, illegal flag and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            ir_r          <= 16'h0000;
            alu_op_r      <= ALU_ADD;
            illegal_r     <= 1'b0;
            instr_count_r <= 16'h0000;
        end else begin
            if (state_r == ST_FETCH && bus.mem_ack) begin
                ir_r <= bus.mem_rdata;
                pc_r <= pc_r + 16'd1;
            end
            if (state_r == ST_DECODE) begin
                if (legal_s) begin
                    alu_op_r <= dec_alu_op_s;
                end else begin
                    illegal_r <= 1'b1;
                end
            end
            if (state_r == ST_WB) begin
                instr_count_r <= instr_count_r + 16'd1;
            end
        end
    end

    assign bus.mem_req     = mem_req_r;
    assign bus.pc          = pc_r;
    assign bus.ir          = ir_r;
    assign bus.alu_op      = alu_op_r;
    assign bus.alu_en      = alu_en_r;
    assign bus.rf_raddr_a  = rdst_s;
    assign bus.rf_raddr_b  = rsrc_s;
    assign bus.rf_waddr    = rdst_s;
    assign bus.rf_we       = rf_we_r;
    assign bus.flags_we    = flags_we_r;
    assign bus.illegal     = illegal_r;
    assign bus.state       = state_r;
    assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction transaction model
// driven by opcode tables, randomized words and ack wait states.
module tb_cpu_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [15:0] m_pc;
    logic [15:0] m_count;
    logic [3:0]  m_alu;

    // Legal opcodes listed in ALU-op order: index == expected alu_op
    logic [7:0] legal_ops [13] = '{8'h05, 8'h06, 8'h07, 8'h09, 8'h0B, 8'h01,
                                   8'h02, 8'h03, 8'h04, 8'h84, 8'h08, 8'h0C, 8'h0F};

    cpu_sequencer_if bus ();
    cpu_sequencer_if bus2 ();

    cpu_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cpu_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.run = 1'b0;
        bus.mem_ack = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_pc = 16'h0000;
        m_count = 16'h0000;
        m_alu = 4'd0;
    endtask

    function automatic int op_index(input logic [7:0] op);
        int idx;
        idx = -1;
        for (int k = 0; k < 13; k++) begin
            if (legal_ops[k] == op) idx = k;
        end
        return idx;
    endfunction

    // Runs one instruction starting in FETCH, checking every cycle
    task automatic do_instr(input logic [15:0] word, input int waits, input bit run_after);
        int idx;
        bit fl;
        logic [63:0] got, want;
        idx = op_index(word[15:8]);
        fl = (idx == 0) || (idx == 2) || (idx == 3) || (idx == 4);
        for (int w = 0; w <= waits; w++) begin
            got  = {bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we, bus.pc};
            want = {3'd1, 4'b1000, m_pc};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fetch w=%0d got=%h want=%h", w, got, want);
            end
            bus.mem_ack = (w == waits);
            bus.mem_rdata = (w == waits) ? word : 16'($urandom);
            tick();
        end
        m_pc = m_pc + 16'd1;
        bus.mem_ack = 1'($urandom);
        bus.mem_rdata = 16'($urandom);
        got  = {bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we, bus.ir, bus.pc,
                bus.rf_raddr_a, bus.rf_raddr_b, bus.rf_waddr};
        want = {3'd2, 4'b0000, word, m_pc, word[7:4], word[3:0], word[7:4]};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL decode got=%h want=%h", got, want);
        end
        tick();
        if (idx < 0) begin
            got  = {bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we,
                    bus.illegal, bus.instr_count, bus.alu_op};
            want = {3'd5, 4'b0000, 1'b1, m_count, m_alu};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL halt got=%h want=%h", got, want);
            end
            return;
        end
        m_alu = idx[3:0];
        got  = {bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we, bus.alu_op, bus.instr_count};
        want = {3'd3, 1'b0, 1'b1, 1'b0, fl, m_alu, m_count};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL exec op=%h got=%h want=%h", word[15:8], got, want);
        end
        bus.run = run_after;
        tick();
        got  = {bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we, bus.alu_op, bus.instr_count};
        want = {3'd4, 1'b0, 1'b0, (idx != 4), 1'b0, m_alu, m_count};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL wb op=%h got=%h want=%h", word[15:8], got, want);
        end
        tick();
        m_count = m_count + 16'd1;
        got  = {bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we, bus.instr_count};
        want = {(run_after ? 3'd1 : 3'd0), run_after, 3'b000, m_count};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL retire got=%h want=%h", got, want);
        end
    endtask

    task automatic test_reset();
        logic [63:0] got, want;
        reset = 1'b1;
        #1;
        got  = {bus.state, bus.pc, bus.ir, bus.alu_op, bus.illegal, bus.instr_count,
                bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we};
        want = {3'd0, 16'h0000, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'b0000};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", got, want);
        end
        apply_reset();
        tick();
        total++;
        if ({bus.state, bus.mem_req} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL idle_hold got=%h want=%h", {bus.state, bus.mem_req}, 4'h0);
        end
    endtask

    task automatic test_single_add();
        apply_reset();
        bus.run = 1'b1;
        tick();
        do_instr(16'h0512, 0, 1'b0);
        tick();
        tick();
        total++;
        if ({bus.state, bus.mem_req, bus.pc} !== {3'd0, 1'b0, 16'h0001}) begin
            bad++;
            $display("FAIL run_drop got=%h want=%h", {bus.state, bus.mem_req, bus.pc}, {3'd0, 1'b0, 16'h0001});
        end
    endtask

    task automatic test_cmp();
        bus.run = 1'b1;
        tick();
        do_instr(16'h0B34, 0, 1'b0);
    endtask

    task automatic test_wait_states();
        bus.run = 1'b1;
        tick();
        do_instr({legal_ops[$urandom_range(0, 12)], 8'($urandom)}, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.run = 1'b1;
        tick();
        for (int n = 0; n < 24; n++) begin
            do_instr({legal_ops[$urandom_range(0, 12)], 8'($urandom)},
                     int'($urandom_range(0, 3)), (n != 23));
        end
    endtask

    task automatic test_illegal();
        logic [7:0] op;
        for (int t = 0; t < 2; t++) begin
            apply_reset();
            op = 8'hFF;
            if (t == 1) begin
                do op = 8'($urandom); while (op_index(op) >= 0);
            end
            bus.run = 1'b1;
            tick();
            do_instr({op, 8'($urandom)}, int'($urandom_range(0, 2)), 1'b1);
            for (int c = 0; c < 6; c++) begin
                bus.run = 1'($urandom);
                bus.mem_ack = 1'b1;
                tick();
                total++;
                if ({bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we, bus.illegal, bus.pc}
                    !== {3'd5, 4'b0000, 1'b1, m_pc}) begin
                    bad++;
                    $display("FAIL halt_absorb got=%h want=%h",
                             {bus.state, bus.mem_req, bus.alu_en, bus.rf_we, bus.flags_we, bus.illegal, bus.pc},
                             {3'd5, 4'b0000, 1'b1, m_pc});
                end
            end
            apply_reset();
            total++;
            if ({bus.state, bus.illegal} !== {3'd0, 1'b0}) begin
                bad++;
                $display("FAIL halt_exit got=%h want=%h", {bus.state, bus.illegal}, 4'h0);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        bus.run = 1'b1;
        tick();
        do_instr(16'h0321, 0, 1'b1);
        bus.mem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        total++;
        if ({bus.state, bus.mem_req, bus.pc} !== {3'd0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_in_fetch got=%h want=%h", {bus.state, bus.mem_req, bus.pc}, 20'h0);
        end
        bus.run = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h0512;
        tick();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.state, bus.mem_req, bus.pc, bus.ir} !== {3'd0, 1'b0, 16'h0000, 16'h0000}) begin
            bad++;
            $display("FAIL late_ack got=%h want=%h", {bus.state, bus.mem_req, bus.pc, bus.ir}, 36'h0);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
        int          at [4]     = '{1, 2, 5, 6};
        int          k;
        apply_reset();
        bus2.run = 1'b1;
        bus2.mem_ack = 1'b1;
        bus2.mem_rdata = 16'h0512;
        k = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == at[k]) begin
                total++;
                if (bus2.pc !== exp_pc[k]) begin
                    bad++;
                    $display("FAIL pc_wrap step=%0d got=%h want=%h", k, bus2.pc, exp_pc[k]);
                end
                if (k < 3) k++;
            end
        end
        bus2.run = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if ({bus2.state, bus2.instr_count} !== {3'd0, 16'h0002}) begin
            bad++;
            $display("FAIL wrap_count got=%h want=%h", {bus2.state, bus2.instr_count}, {3'd0, 16'h0002});
        end
        // Counter wrap: preload in IDLE, then retire one instruction
        force dut.instr_count_r = 16'hFFFF;
        tick();
        release dut.instr_count_r;
        #1;
        if (bus.instr_count === 16'hFFFF) begin
            m_count = 16'hFFFF;
            bus.run = 1'b1;
            tick();
            do_instr(16'h0612, 0, 1'b0);
            total++;
            if (bus.instr_count !== 16'h0000) begin
                bad++;
                $display("FAIL count_wrap got=%h want=%h", bus.instr_count, 16'h0000);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus2.run = 1'b0;
        bus2.mem_ack = 1'b0;
        bus2.mem_rdata = 16'h0000;
        m_pc = 16'h0000;
        m_count = 16'h0000;
        m_alu = 4'd0;
        tick();
        test_reset();
        test_single_add();
        test_cmp();
        test_wait_states();
        test_back_to_back();
        test_illegal();
        test_reset_mid_fetch();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the 16-bit CPU. It fetches instruction words from instruction memory through a req/ack handshake, holds them in an instruction register that feeds the `decoder` instance, and maps the 8-bit opcode to an ALU operation. It then sequences execute and register-file writeback, one instruction at a time. It sits between instruction memory, the register file, the ALU and the flags register.

## Interface
Parameters:
- RESET_PC, 16'h0000, value loaded into `pc` on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- run  in  1  level enable; sampled in IDLE and at end of WB.
- mem_ack  in  1  instruction data valid; honoured only in FETCH.
- mem_rdata  in  16  instruction word, valid when mem_ack=1.
- mem_req  out  1  instruction fetch request.
- pc  out  16  fetch address.
- ir  out  16  instruction register; drives the decoder input.
- alu_op  out  4  ALU operation code.
- alu_en  out  1  ALU operands/result valid this cycle.
- rf_raddr_a  out  4  rdst field (ir[7:4]).
- rf_raddr_b  out  4  rsrc field (ir[3:0]).
- rf_waddr  out  4  write address (ir[7:4]).
- rf_we  out  1  register-file write strobe.
- flags_we  out  1  flags register write strobe.
- illegal  out  1  sticky illegal-opcode indicator.
- state  out  3  current FSM state (debug).
- instr_count  out  16  retired-instruction counter.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- **IDLE**
  - All strobes are 0.
  - Go to FETCH when run=1; otherwise stay.
- **FETCH**
  - mem_req=1 and pc is held stable.
  - On mem_ack=1: ir<=mem_rdata, pc<=pc+1 (16'hFFFF wraps to 16'h0000), go to DECODE.
  - Otherwise stay, with no timeout.
- **DECODE**
  - Classify ir[15:8]: add 8'h05, addu 8'h06, addc 8'h07, sub 8'h09, cmp 8'h0B, and 8'h01, or 8'h02, xor 8'h03, not 8'h04, lsh 8'h84, rsh 8'h08, alsh 8'h0C, arsh 8'h0F.
  - Legal opcode: register alu_op and go to EXEC.
  - Any other opcode: illegal<=1, go to HALT.
- **alu_op mapping:** ADD 0, ADDU 1, ADDC 2, SUB 3, CMP 4, AND 5, OR 6, XOR 7, NOT 8, LSH 9, RSH 10, ALSH 11, ARSH 12.
- **EXEC**
  - alu_en=1.
  - flags_we=1 for add, addc, sub, cmp; 0 for all others.
  - Go to WB.
- **WB**
  - rf_we=1 for every legal op except cmp.
  - instr_count<=instr_count+1, wrapping 16'hFFFF to 0.
  - Go to FETCH if run=1, else IDLE.
- **HALT:** absorbing; only reset exits. All strobes are 0.
- alu_op holds its registered value from DECODE until the next DECODE.
- rf_raddr_a, rf_raddr_b and rf_waddr are combinational slices of ir.
- run=0 mid-instruction: the current instruction completes, then IDLE.
- mem_ack asserted outside FETCH is ignored.

## Timing
- **Reset values:** state=IDLE, pc=RESET_PC, ir=0, alu_op=0, illegal=0, instr_count=0. mem_req, alu_en, rf_we and flags_we are 0.
- mem_req, alu_en, rf_we and flags_we are decoded from state, so each is high for exactly the cycles spent in its state.
- **Minimum instruction latency:** 4 cycles (mem_ack high in the first FETCH cycle). Each ack-wait cycle adds one.
- Back-to-back instructions with run=1: WB is followed directly by FETCH, with no idle cycle.
- **Reset asserted mid-operation (any state):**
  - All outputs return to reset values asynchronously.
  - Any pending fetch is abandoned.
  - A late mem_ack after reset is ignored, because the FSM is then in IDLE.
- **Illegal opcode:** illegal rises at the DECODE→HALT edge. No EXEC/WB strobe occurs and instr_count is not incremented.

## Structure
- Shared package `cpu_pkg` holds:
  - 8-bit opcode constants,
  - 4-bit alu_op encodings,
  - 3-bit FSM state encodings.
- One sub-module: the existing `decoder`, instantiated on `ir`. Its opcode, rdst and rsrc outputs are used; its immediate output is unused.
- Illegal-opcode detection is a local case statement over `cpu_pkg` constants. It does not rely on the decoder.

## Test plan
- **Single add:** reset, run=1, mem_ack tied 1, mem_rdata=16'h0512.
  - pc 0→1; DECODE at cycle 2, EXEC at cycle 3, WB at cycle 4.
  - alu_op=0, flags_we and rf_we pulse once, rf_waddr=1, instr_count=1.
- **cmp:** mem_rdata=16'h0B34.
  - flags_we=1 in EXEC, rf_we stays 0 in WB, alu_op=4.
- **Wait states:** mem_ack delayed 3 cycles.
  - mem_req high for 4 cycles with pc constant; instruction completes in 7 cycles.
- **Illegal opcode:** mem_rdata=16'hFF00.
  - illegal=1, state=5, no rf_we/flags_we.
  - run toggling has no effect; only reset returns to state=0.
- **Wrap-around:** RESET_PC=16'hFFFF, execute 2 instructions.
  - pc becomes 16'h0000, then 16'h0001.
  - Separately, preload instr_count to 16'hFFFF and retire one instruction: instr_count becomes 16'h0000.
- **Control edges:**
  - run dropped during EXEC → WB completes, state returns to IDLE, and no new mem_req.
  - reset asserted during FETCH wait → mem_req falls immediately and pc=RESET_PC.
